uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter between several byte requesters. It sits in front of the UART TX top level. It selects one pending requester and drives that requester's byte and parity configuration onto the transmitter with a one-cycle `Data_valid` pulse. It then tracks the transmitter's `Busy` through the frame and returns a one-cycle `Ack` when the frame has left the line.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 1..8.
- `DATA_WIDTH`, default 8: byte width; must match the transmitter.
- `START_TIMEOUT`, default 15: maximum number of WAIT_BUSY cycles allowed for `Busy` to rise before the frame is abandoned.

Ports:
- `CLK`, in, 1: transmitter clock. The block has one clock.
- `RST`, in, 1: reset, asynchronous and active-high.
- `Req`, in, NUM_REQ: per-requester level request, held until `Ack`.
- `Req_Data`, in, NUM_REQ*DATA_WIDTH: packed bytes; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- `Req_Par_EN`, in, NUM_REQ: per-requester parity enable.
- `Req_Par_type`, in, NUM_REQ: per-requester parity type.
- `Grant`, out, NUM_REQ: one-hot; set to the served requester for the whole frame.
- `Ack`, out, NUM_REQ: one-cycle pulse on completion, one-hot.
- `Timeout_Err`, out, 1: one-cycle pulse when a frame is abandoned.
- `P_Data`, out, DATA_WIDTH: byte to the transmitter.
- `Data_valid`, out, 1: one-cycle start strobe to the transmitter.
- `Par_EN`, out, 1: parity enable to the transmitter.
- `Par_type`, out, 1: parity type to the transmitter.
- `Busy`, in, 1: busy flag from the transmitter.

## Operation
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE:
  - Leaves only when `Busy`=0 and at least one `Req` bit is 1.
  - The winner is the first requester with `Req`=1, searching from `last_ptr`+1 upward with modulo-NUM_REQ wrap.
  - On the same edge, registers `Grant`, `P_Data`, `Par_EN` and `Par_type` from the winner, and updates `last_ptr` to the winner. Next state is LOAD.
- LOAD: `Data_valid`=1 for exactly this one cycle. Next state is WAIT_BUSY; the timeout counter is cleared.
- WAIT_BUSY:
  - If `Busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT, pulse `Timeout_Err`, clear `Grant`, give no `Ack`, and go to IDLE.
- WAIT_DONE: stay while `Busy`=1. When `Busy`=0, go to ACK.
- ACK: `Ack[winner]`=1 for one cycle and `Grant` is still held. Next state is IDLE, with `Grant` cleared on that edge.
- `P_Data`, `Par_EN` and `Par_type` stay stable from LOAD through ACK. They hold their last value in IDLE.
- `Req` is ignored outside IDLE. Deasserting `Req` mid-frame does not abort the frame; `Ack` is still pulsed.
- `Req_Data`, `Req_Par_EN` and `Req_Par_type` are sampled only on the IDLE→LOAD edge.
- An abandoned frame still advances `last_ptr`, so a stuck requester cannot starve the others.
- The timeout counter is $clog2(START_TIMEOUT+1) bits wide and saturates.

## Timing
- Reset (asynchronous, active-high): state=IDLE and `last_ptr`=NUM_REQ-1, so requester 0 wins first. `Grant`, `Ack`, `Timeout_Err`, `P_Data`, `Data_valid`, `Par_EN` and `Par_type` are all 0.
- Requests sampled in IDLE at cycle N give `Data_valid`=1 at N+1.
- `Busy`=0 sampled in WAIT_DONE at cycle M gives `Ack`=1 at M+1 and IDLE at M+2. The earliest next `Data_valid` is at M+3.
- Requesters must drop `Req` on the edge after seeing `Ack`. The next IDLE evaluation then sees it low.
- If `Busy`=1 while in IDLE, arbitration is held until `Busy`=0.
- Reset mid-frame: every output returns to its reset value immediately, with no `Ack` or `Timeout_Err`. The transmitter shares `RST`.
- NUM_REQ=1: rotation degenerates to always requester 0; behaviour is otherwise identical.

## Test plan
- Single request: `Req`=0001, byte 0xA5, `Req_Par_EN`=1, `Req_Par_type`=0, driving a real transmitter.
  - `Data_valid` pulses exactly once, one cycle after `Req` is seen.
  - `Grant`=0001 throughout the frame; `Ack`=0001 pulses one cycle after `Busy` falls.
  - The transmitter output shows 0xA5 with even parity.
- Round-robin: `Req`=1111 held, each requester re-asserting after its `Ack`.
  - Grant order is 0,1,2,3,0.
  - Each `Data_valid` is exactly 3 cycles after the previous `Ack`'s WAIT_DONE exit.
- Fairness after a skip: after a grant to requester 2, present `Req`=0101.
  - Requester 0 is granted next, via wrap, not requester 2.
- Timeout: replace the transmitter with a model that holds `Busy`=0, `Req`=0010.
  - `Timeout_Err` pulses START_TIMEOUT+2 cycles after `Data_valid`.
  - No `Ack` is issued and `Grant` clears.
  - With `Req`=0011, the next grant goes to requester 0.
- Mid-frame events:
  - Drop `Req` during WAIT_DONE: the frame completes and `Ack` still pulses.
  - Assert `RST` during WAIT_DONE: all outputs are 0 in the same cycle; after release, requester 0 wins first.
- Busy at idle: force `Busy`=1 with `Req`=0001. No `Data_valid` is issued until `Busy`=0, then `Data_valid` follows one cycle later.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ byte requesters.
// Issues a one-cycle Data_valid, tracks Busy through the frame, then pulses Ack (or Timeout_Err).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]            Req_Par_EN,
  input  logic [NUM_REQ-1:0]            Req_Par_type,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Ack,
  output logic                          Timeout_Err,
  output logic [DATA_WIDTH-1:0]         P_Data,
  output logic                          Data_valid,
  output logic                          Par_EN,
  output logic                          Par_type,
  input  logic                          Busy
);

  localparam int unsigned    PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned    CntW   = $clog2(START_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(START_TIMEOUT);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitBusy, StWaitDone, StAck} state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         last_ptr_q, last_ptr_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_type_q, par_type_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic                    found;
  logic [PtrW-1:0]         win_idx;
  logic [PtrW-1:0]         scan_idx;

  // Search upward from last_ptr+1 with wrap; the first pending requester wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = last_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == PtrLast) ? '0 : scan_idx + 1'b1;
      if (!found && Req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!Busy && found) begin
          state_d          = StLoad;
          last_ptr_d       = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          data_d           = Req_Data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          par_en_d         = Req_Par_EN[win_idx];
          par_type_d       = Req_Par_type[win_idx];
        end
      end
      StLoad: begin
        state_d = StWaitBusy;
        cnt_d   = '0;
      end
      StWaitBusy: begin
        if (Busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntMax) begin
          // Abandon the frame; last_ptr already moved so the next search skips this requester.
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!Busy) state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      last_ptr_q <= PtrLast;
      grant_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Grant       = grant_q;
  assign Ack         = (state_q == StAck) ? grant_q : '0;
  assign Data_valid  = (state_q == StLoad);
  assign Timeout_Err = timeout_q;
  assign P_Data      = data_q;
  assign Par_EN      = par_en_q;
  assign Par_type    = par_type_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of arbitration frames plus hand-written corner sequences.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned ST = 15;

  logic           CLK, RST;
  logic [NR-1:0]  Req, Req_Par_EN, Req_Par_type, Grant, Ack;
  logic [NR*DW-1:0] Req_Data;
  logic           Timeout_Err, Data_valid, Par_EN, Par_type, Busy;
  logic [DW-1:0]  P_Data;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .START_TIMEOUT (ST)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Req          (Req),
    .Req_Data     (Req_Data),
    .Req_Par_EN   (Req_Par_EN),
    .Req_Par_type (Req_Par_type),
    .Grant        (Grant),
    .Ack          (Ack),
    .Timeout_Err  (Timeout_Err),
    .P_Data       (P_Data),
    .Data_valid   (Data_valid),
    .Par_EN       (Par_EN),
    .Par_type     (Par_type),
    .Busy         (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    pe;
    logic [NR-1:0]    pt;
    int               busy_len;
    logic [NR-1:0]    exp_grant;
    logic [DW-1:0]    exp_data;
    logic             exp_pe;
    logic             exp_pt;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  // Present a request in IDLE; the next edge must land in LOAD with the winner registered.
  task automatic start_frame(input logic [NR-1:0] req, input logic [NR*DW-1:0] data,
                             input logic [NR-1:0] pe, input logic [NR-1:0] pt,
                             input logic [NR-1:0] eg, input logic [DW-1:0] ed,
                             input logic epe, input logic ept);
    Req = req; Req_Data = data; Req_Par_EN = pe; Req_Par_type = pt;
    tick();
    chk("dv_load", 32'(Data_valid), 32'd1);
    chk("grant_load", 32'(Grant), 32'(eg));
    chk("pdata_load", 32'(P_Data), 32'(ed));
    chk("paren_load", 32'(Par_EN), 32'(epe));
    chk("partype_load", 32'(Par_type), 32'(ept));
    // Scramble inputs: outputs must keep the values captured on the IDLE->LOAD edge.
    Req_Data = ~data; Req_Par_EN = ~pe; Req_Par_type = ~pt;
  endtask

  task automatic finish_frame(input int busy_len, input bit drop_early,
                              input logic [NR-1:0] eg, input logic [DW-1:0] ed,
                              input logic epe, input logic ept);
    Busy = 1'b1;
    tick();
    chk("dv_once", 32'(Data_valid), 32'd0);
    chk("grant_hold", 32'(Grant), 32'(eg));
    for (int i = 1; i < busy_len; i++) begin
      tick();
      if (drop_early && i == 1) Req = '0;
    end
    chk("ack_early", 32'(Ack), 32'd0);
    Busy = 1'b0;
    tick();
    chk("ack", 32'(Ack), 32'(eg));
    chk("grant_ack", 32'(Grant), 32'(eg));
    chk("pdata_ack", 32'(P_Data), 32'(ed));
    chk("paren_ack", 32'(Par_EN), 32'(epe));
    chk("partype_ack", 32'(Par_type), 32'(ept));
    chk("no_timeout", 32'(Timeout_Err), 32'd0);
    Req = '0;
    tick();
    chk("ack_clear", 32'(Ack), 32'd0);
    chk("grant_clear", 32'(Grant), 32'd0);
    chk("dv_idle", 32'(Data_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 32'h0000_00A5, 4'b0001, 4'b0000, 3, 4'b0001, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{4'b1111, 32'h4433_2211, 4'b1010, 4'b0110, 2, 4'b0010, 8'h22, 1'b1, 1'b1};
    vecs[2] = '{4'b1111, 32'h4433_2211, 4'b1010, 4'b0110, 4, 4'b0100, 8'h33, 1'b0, 1'b1};
    vecs[3] = '{4'b1111, 32'h4433_2211, 4'b1010, 4'b0110, 2, 4'b1000, 8'h44, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 32'h4433_2211, 4'b1010, 4'b0110, 5, 4'b0001, 8'h11, 1'b0, 1'b0};
    vecs[5] = '{4'b0100, 32'h00CC_0000, 4'b0100, 4'b0100, 3, 4'b0100, 8'hCC, 1'b1, 1'b1};
    vecs[6] = '{4'b0101, 32'h005A_0096, 4'b0000, 4'b0001, 2, 4'b0001, 8'h96, 1'b0, 1'b1};
    vecs[7] = '{4'b0110, 32'h0077_8800, 4'b0010, 4'b0000, 3, 4'b0010, 8'h88, 1'b1, 1'b0};
    vecs[8] = '{4'b1001, 32'hE100_0000, 4'b1000, 4'b1000, 2, 4'b1000, 8'hE1, 1'b1, 1'b1};

    RST = 1'b1; Busy = 1'b0; Req = '0; Req_Data = '0; Req_Par_EN = '0; Req_Par_type = '0;
    tick();
    tick();
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_dv", 32'(Data_valid), 32'd0);
    chk("rst_pdata", 32'(P_Data), 32'd0);
    chk("rst_timeout", 32'(Timeout_Err), 32'd0);
    RST = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      start_frame(vecs[v].req, vecs[v].data, vecs[v].pe, vecs[v].pt,
                  vecs[v].exp_grant, vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_pt);
      finish_frame(vecs[v].busy_len, 1'b0,
                   vecs[v].exp_grant, vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_pt);
    end

    // Timeout: Busy never rises; error pulse ST+2 cycles after Data_valid, then fair re-arbitration.
    start_frame(4'b0010, 32'h0000_5500, 4'b0010, 4'b0000, 4'b0010, 8'h55, 1'b1, 1'b0);
    for (int k = 1; k <= int'(ST) + 2; k++) begin
      tick();
      chk("to_pulse", 32'(Timeout_Err), (k == int'(ST) + 2) ? 32'd1 : 32'd0);
      chk("to_grant", 32'(Grant), (k == int'(ST) + 2) ? 32'd0 : 32'b0010);
      chk("to_noack", 32'(Ack), 32'd0);
    end
    start_frame(4'b0011, 32'h0000_6677, 4'b0001, 4'b0001, 4'b0001, 8'h77, 1'b1, 1'b1);
    finish_frame(3, 1'b0, 4'b0001, 8'h77, 1'b1, 1'b1);

    // Req dropped during WAIT_DONE: frame still completes with Ack.
    start_frame(4'b0100, 32'h0099_0000, 4'b0000, 4'b0000, 4'b0100, 8'h99, 1'b0, 1'b0);
    finish_frame(4, 1'b1, 4'b0100, 8'h99, 1'b0, 1'b0);

    // Reset during WAIT_DONE clears outputs at once; requester 0 wins afterwards.
    start_frame(4'b1000, 32'hAB00_0000, 4'b1000, 4'b0000, 4'b1000, 8'hAB, 1'b1, 1'b0);
    Busy = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk("mrst_grant", 32'(Grant), 32'd0);
    chk("mrst_ack", 32'(Ack), 32'd0);
    chk("mrst_dv", 32'(Data_valid), 32'd0);
    chk("mrst_pdata", 32'(P_Data), 32'd0);
    chk("mrst_par", 32'({Par_EN, Par_type, Timeout_Err}), 32'd0);
    Busy = 1'b0; Req = '0;
    tick();
    RST = 1'b0;
    tick();
    chk("mrst_idle_ack", 32'(Ack), 32'd0);
    start_frame(4'b1111, 32'h0403_0201, 4'b1111, 4'b0000, 4'b0001, 8'h01, 1'b1, 1'b0);
    finish_frame(2, 1'b0, 4'b0001, 8'h01, 1'b1, 1'b0);

    // Busy high in IDLE holds arbitration off.
    Busy = 1'b1; Req = 4'b0001; Req_Data = 32'h0000_00C3; Req_Par_EN = '0; Req_Par_type = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busyidle_dv", 32'(Data_valid), 32'd0);
      chk("busyidle_grant", 32'(Grant), 32'd0);
    end
    Busy = 1'b0;
    tick();
    chk("busyidle_dv_go", 32'(Data_valid), 32'd1);
    chk("busyidle_grant_go", 32'(Grant), 32'b0001);
    finish_frame(2, 1'b0, 4'b0001, 8'hC3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
